// File: rtl/brightness_pkg.sv
// Shared brightness types and helpers: fade FSM state encoding and the
// saturating step used to walk a mask toward its target.
package brightness_pkg;

  typedef enum logic [1:0] {
    BF_IDLE       = 2'd0,
    BF_WAIT_FRAME = 2'd1,
    BF_STEP       = 2'd2,
    BF_DONE       = 2'd3
  } bfade_state_t;

  // Operands are zero-extended to 32 bits and compared in 33 bits, so the
  // result never wraps and never passes tgt: when the remaining distance is
  // at most step, tgt itself is returned.
  function automatic logic [31:0] step_toward(input logic [31:0] cur,
                                              input logic [31:0] tgt,
                                              input logic [31:0] step);
    logic [32:0] diff;
    logic [31:0] res;
    res = cur;
    if (tgt > cur) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      res  = (diff <= {1'b0, step}) ? tgt : (cur + step);
    end else if (tgt < cur) begin
      diff = {1'b0, cur} - {1'b0, tgt};
      res  = (diff <= {1'b0, step}) ? tgt : (cur - step);
    end
    return res;
  endfunction

endpackage

// File: rtl/frame_tick_divider.sv
// Counts frame_sync pulses and emits tick on every FADE_FRAMES-th one.
// clear restarts the count; a tick also restarts it.
module frame_tick_divider #(
  parameter int FADE_FRAMES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_sync,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FADE_FRAMES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // tick does not depend on clear, so a request landing on the qualifying
  // frame_sync still lets that step happen.
  assign tick = frame_sync && (cnt_q == LAST);

  // Next count: restart on clear or tick, advance on each frame_sync.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || tick) begin
      cnt_d = '0;
    end else if (frame_sync) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/brightness_fade_ctrl.sv
// Brightness mask sequencer: latches a requested target and moves the
// applied mask toward it only on frame boundaries, either in one jump or
// in STEP_SIZE increments every FADE_FRAMES frames.
module brightness_fade_ctrl
  import brightness_pkg::*;
#(
  parameter int BRIGHTNESS_LEVELS = 6,
  parameter int FADE_FRAMES       = 4,
  parameter int STEP_SIZE         = 1,
  parameter logic [BRIGHTNESS_LEVELS-1:0] RESET_BRIGHTNESS = '1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_en,
  input  logic [BRIGHTNESS_LEVELS-1:0] req_value,
  input  logic                         fade_enable,
  input  logic                         frame_sync,
  output logic [BRIGHTNESS_LEVELS-1:0] brightness_mask,
  output logic                         busy,
  output logic                         done
);

  localparam int BL = BRIGHTNESS_LEVELS;

  bfade_state_t state_q, state_d;
  logic [BL-1:0] mask_q, mask_d;
  logic [BL-1:0] target_q, target_d;
  logic          req_seen_q, req_seen_d;
  logic          done_q, done_d;

  logic          tick;
  logic          div_clear;
  logic          qual_sync;
  logic [BL-1:0] step_val;
  logic          req_hits_mask;

  // The frame counter only runs while waiting for a step; any request
  // restarts it so the fade cadence is measured from the new target.
  assign div_clear = req_en || (state_q != BF_WAIT_FRAME);

  frame_tick_divider #(
    .FADE_FRAMES(FADE_FRAMES)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .frame_sync(frame_sync),
    .clear     (div_clear),
    .tick      (tick)
  );

  // A jump waits for any frame boundary; a fade waits for the divider.
  assign qual_sync = frame_sync && (!fade_enable || tick);
  assign step_val  = BL'(step_toward(32'(mask_q), 32'(target_q), 32'(STEP_SIZE)));

  // A fresh request is compared directly so an equal retarget ends the fade
  // right away instead of waiting for target_q to update.
  assign req_hits_mask = req_en ? (req_value == mask_q) : (target_q == mask_q);

  // Next-state, next-mask and target capture.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    target_d   = req_en ? req_value : target_q;
    req_seen_d = req_en;
    case (state_q)
      BF_IDLE: begin
        if (target_q != mask_q) begin
          state_d = BF_WAIT_FRAME;
        end else if (req_seen_q) begin
          state_d = BF_DONE;
        end
      end
      BF_WAIT_FRAME: begin
        // target_q still holds the old target when a request coincides with
        // the qualifying frame_sync, so that step heads for the old value.
        if (qual_sync) begin
          state_d = BF_STEP;
          mask_d  = fade_enable ? step_val : target_q;
        end else if (req_hits_mask) begin
          state_d = BF_DONE;
        end
      end
      BF_STEP: begin
        state_d = (mask_q != target_q) ? BF_WAIT_FRAME : BF_DONE;
      end
      BF_DONE: begin
        state_d = BF_IDLE;
      end
      default: begin
        state_d = BF_IDLE;
      end
    endcase
    done_d = (state_d == BF_DONE);
  end

  // State, mask, target and done registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BF_IDLE;
      mask_q     <= RESET_BRIGHTNESS;
      target_q   <= RESET_BRIGHTNESS;
      req_seen_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      target_q   <= target_d;
      req_seen_q <= req_seen_d;
      done_q     <= done_d;
    end
  end

  assign brightness_mask = mask_q;
  assign busy            = (state_q != BF_IDLE) && (state_q != BF_DONE);
  assign done            = done_q;

endmodule
